spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave running entirely on clk.
// The SPI pins are treated as asynchronous inputs. They are synchronized and
// oversampled, and sck edges are detected in the clk domain.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   ss           slave select, active-low (asynchronous)
//   sck          SPI clock (asynchronous)
//   mosi         serial data from master, MSB first
//   miso         serial data to master; high-Z while synchronized ss is high
//   tx_data      byte to return in the next frame
//   tx_valid     tx_data valid (write into TX holding buffer)
//   tx_ready     TX holding buffer empty
//   rx_data      last byte received
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer accepts rx_data
//   rx_overrun   one-cycle pulse: received byte dropped
//   tx_underrun  one-cycle pulse: frame started with empty TX buffer
//   frame_err    one-cycle pulse: ss released before 8 bits
//   busy         synchronized ss is low
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;

    logic [SYNC_STAGES-1:0] ss_sync_r, sck_sync_r, mosi_sync_r;
    logic ss_hist_r, sck_hist_r;
    logic ss_s, sck_s, mosi_s;
    logic ss_fall_s, ss_rise_s, sck_rise_s, sck_fall_s;
    logic frame_start_s, byte_done_s, abort_s;

    logic [3:0] bit_cnt_r;
    logic [7:0] rx_shift_r, tx_shift_r, tx_buf_r, rx_data_r;
    logic [7:0] rx_byte_s;
    logic       tx_full_r, rx_valid_r;
    logic       rx_overrun_r, tx_underrun_r, frame_err_r;
    logic       miso_s;

    // Synchronizer chains plus one history flop each for ss/sck edge detection.
    // Presets match an idle bus (ss high, sck low) so reset creates no edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            ss_hist_r   <= 1'b1;
            sck_hist_r  <= 1'b0;
        end else begin
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            ss_hist_r   <= ss_sync_r[SYNC_STAGES-1];
            sck_hist_r  <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    assign ss_s       = ss_sync_r[SYNC_STAGES-1];
    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign ss_fall_s  = ss_hist_r & ~ss_s;
    assign ss_rise_s  = ~ss_hist_r & ss_s;
    assign sck_rise_s = ~sck_hist_r & sck_s;
    assign sck_fall_s = sck_hist_r & ~sck_s;

    // An ss release always wins over a coincident sck edge.
    assign frame_start_s = (state_r == ST_IDLE) && ss_fall_s;
    assign abort_s       = (state_r == ST_SHIFT) && ss_rise_s;
    assign byte_done_s   = (state_r == ST_SHIFT) && !ss_rise_s && sck_rise_s
                           && (bit_cnt_r == 4'd7);
    assign rx_byte_s     = {rx_shift_r[6:0], mosi_s};

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (sck_rise_s && (bit_cnt_r == 4'd7)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: miso is forced low once the byte is complete.
    always_comb begin
        miso_s = 1'b0;
        case (state_r)
            ST_DONE:  miso_s = 1'b0;
            ST_IDLE:  miso_s = tx_shift_r[7];
            ST_SHIFT: miso_s = tx_shift_r[7];
            default:  miso_s = 1'b0;
        endcase
    end

    assign miso = ss_s ? 1'bz : miso_s;
    assign busy = ~ss_s;

    // Bit counter and RX shift register; both restart at frame start and on abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_r  <= 4'd0;
            rx_shift_r <= 8'h00;
        end else if (frame_start_s || ss_rise_s) begin
            bit_cnt_r  <= 4'd0;
            rx_shift_r <= 8'h00;
        end else if ((state_r == ST_SHIFT) && sck_rise_s) begin
            bit_cnt_r  <= bit_cnt_r + 4'd1;
            rx_shift_r <= rx_byte_s;
        end else begin
            bit_cnt_r  <= bit_cnt_r;
            rx_shift_r <= rx_shift_r;
        end
    end

    // TX shift register: load at frame start, shift out on sck falling edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift_r <= 8'h00;
        end else if (frame_start_s) begin
            tx_shift_r <= tx_full_r ? tx_buf_r : 8'h00;
        end else if ((state_r == ST_SHIFT) && !ss_rise_s && sck_fall_s) begin
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        end else begin
            tx_shift_r <= tx_shift_r;
        end
    end

    // TX holding buffer. A frame start only drains it when it is full, so a
    // write can never collide with the drain on the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_buf_r  <= 8'h00;
            tx_full_r <= 1'b0;
        end else if (frame_start_s && tx_full_r) begin
            tx_buf_r  <= tx_buf_r;
            tx_full_r <= 1'b0;
        end else if (tx_valid && !tx_full_r) begin
            tx_buf_r  <= tx_data;
            tx_full_r <= 1'b1;
        end else begin
            tx_buf_r  <= tx_buf_r;
            tx_full_r <= tx_full_r;
        end
    end

    // RX output register with a valid/ready handshake; a new byte is dropped if
    // the previous one is still pending and not being consumed this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (byte_done_s && (!rx_valid_r || rx_ready)) begin
            rx_data_r  <= rx_byte_s;
            rx_valid_r <= 1'b1;
        end else if (rx_ready) begin
            rx_data_r  <= rx_data_r;
            rx_valid_r <= 1'b0;
        end else begin
            rx_data_r  <= rx_data_r;
            rx_valid_r <= rx_valid_r;
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun_r  <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            rx_overrun_r  <= byte_done_s && rx_valid_r && !rx_ready;
            tx_underrun_r <= frame_start_s && !tx_full_r;
            frame_err_r   <= abort_s;
        end
    end

    assign tx_ready    = ~tx_full_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign rx_overrun  = rx_overrun_r;
    assign tx_underrun = tx_underrun_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed test of spi_slave acting as an SPI mode-0 master.
// Each sck phase lasts 8 clk cycles, which is above the minimum for SYNC_STAGES=2.
// Status pulses are counted by a monitor, and each test checks the change in
// those counts.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       ss, sck, mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun, tx_underrun, frame_err, busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_ovr   = 0;
    int n_und   = 0;
    int n_ferr  = 0;
    int s_ovr, s_und, s_ferr;

    logic [7:0] mi_r;
    logic       miso_done_r;
    logic       busy_seen_r;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor.
    always @(negedge clk) begin
        if (rx_overrun)  n_ovr++;
        if (tx_underrun) n_und++;
        if (frame_err)   n_ferr++;
    end

    // Hard time limit.
    initial begin
        #400us;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_ovr  = n_ovr;
        s_und  = n_und;
        s_ferr = n_ferr;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One master transfer of nbits, MSB first. miso is sampled just before each
    // rising edge, and late in the 8th high phase to see what DONE drives.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit end_ss,
                            output logic [7:0] mi, output logic miso_done,
                            output logic busy_seen);
        mi = 8'h00;
        miso_done = 1'b1;
        busy_seen = 1'b0;
        ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_clk(8);
            if (i == 0) busy_seen = busy;
            mi = {mi[6:0], miso};
            sck = 1'b1;
            wait_clk(6);
            if (i == 7) miso_done = miso;
            wait_clk(2);
            sck = 1'b0;
        end
        if (end_ss) begin
            wait_clk(8);
            ss = 1'b1;
            mosi = 1'b0;
            wait_clk(8);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic consume_rx();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        wait_clk(3);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pulses", {rx_overrun, tx_underrun, frame_err}, 0);
        reset = 1'b0;
        wait_clk(4);

        // Loaded TX byte, master sends 0x3C.
        snap();
        load_tx(8'hA5);
        check_eq("t1_tx_full", tx_ready, 0);
        spi_xfer(8'h3C, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t1_busy_in_frame", busy_seen_r, 1);
        check_eq("t1_miso_byte", mi_r, 8'hA5);
        check_eq("t1_miso_done", miso_done_r, 0);
        check_eq("t1_rx_data", rx_data, 8'h3C);
        check_eq("t1_rx_valid", rx_valid, 1);
        check_eq("t1_tx_ready", tx_ready, 1);
        check_eq("t1_underrun", n_und - s_und, 0);
        check_eq("t1_busy_after", busy, 0);

        // Overrun: 0x3C still pending, master sends 0x55.
        snap();
        spi_xfer(8'h55, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t2_overrun", n_ovr - s_ovr, 1);
        check_eq("t2_rx_data", rx_data, 8'h3C);
        check_eq("t2_rx_valid", rx_valid, 1);
        consume_rx();
        check_eq("t2_consumed", rx_valid, 0);

        // Underrun: no TX byte, master sends 0x11.
        snap();
        spi_xfer(8'h11, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t3_miso_byte", mi_r, 8'h00);
        check_eq("t3_underrun", n_und - s_und, 1);
        check_eq("t3_rx_data", rx_data, 8'h11);
        check_eq("t3_overrun", n_ovr - s_ovr, 0);
        consume_rx();

        // Aborted frame after 3 bits, then a full 0x81 with a mid-frame TX write.
        snap();
        spi_xfer(8'hE0, 3, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t4_frame_err", n_ferr - s_ferr, 1);
        check_eq("t4_rx_valid", rx_valid, 0);
        check_eq("t4_rx_data", rx_data, 8'h11);
        snap();
        fork
            spi_xfer(8'h81, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
            begin
                wait_clk(30);
                load_tx(8'h96);
            end
        join
        check_eq("t4_rx_data_81", rx_data, 8'h81);
        check_eq("t4_frame_err_full", n_ferr - s_ferr, 0);
        check_eq("t4_mid_tx_held", tx_ready, 0);
        consume_rx();
        snap();
        spi_xfer(8'h7E, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t4_next_miso", mi_r, 8'h96);
        check_eq("t4_rx_data_7e", rx_data, 8'h7E);
        check_eq("t4_underrun_next", n_und - s_und, 0);

        // Reset after 4 bits while 0x7E is still pending and TX buffer is full.
        load_tx(8'h5A);
        check_eq("t5_tx_full", tx_ready, 0);
        snap();
        spi_xfer(8'hF0, 4, 1'b0, mi_r, miso_done_r, busy_seen_r);
        reset = 1'b1;
        wait_clk(1);
        check_eq("t5_tx_ready", tx_ready, 1);
        check_eq("t5_rx_valid", rx_valid, 0);
        check_eq("t5_rx_data", rx_data, 8'h00);
        check_eq("t5_busy", busy, 0);
        ss = 1'b1; mosi = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(10);
        check_eq("t5_no_frame_err", n_ferr - s_ferr, 0);
        check_eq("t5_rx_valid_after", rx_valid, 0);
        snap();
        spi_xfer(8'h42, 8, 1'b1, mi_r, miso_done_r, busy_seen_r);
        check_eq("t5_fresh_rx", rx_data, 8'h42);
        check_eq("t5_fresh_miso", mi_r, 8'h00);
        check_eq("t5_fresh_underrun", n_und - s_und, 1);
        check_eq("t5_fresh_frame_err", n_ferr - s_ferr, 0);
        consume_rx();

        // sck activity with ss high has no effect.
        snap();
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sck = 1'b1;
            wait_clk(8);
            sck = 1'b0;
            wait_clk(8);
        end
        wait_clk(8);
        check_eq("t6_rx_valid", rx_valid, 0);
        check_eq("t6_rx_data", rx_data, 8'h42);
        check_eq("t6_pulses", (n_ovr - s_ovr) + (n_und - s_und) + (n_ferr - s_ferr), 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_tx_ready", tx_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
